jk_mod_counter: RTL and testbench

Programmable modulo-N synchronous up/down counter whose state is held in a bank of JK flip-flop cells, one per bit. Each cycle the block computes the next count and derives per-bit J/K excitation from it, then applies that excitation to its own JK register bank. It is the stage directly upstream of a single JK cell, generalised to a WIDTH-bit register. The excitation buses are exported so the lab bench can observe the drive each cell receives.

---
 rtl/jk_pkg.sv | 16 +
 rtl/jk_cell.sv | 30 +++
 rtl/jk_mod_counter.sv | 123 ++++++++++++
 tb/tb_jk_mod_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK excitation codes and the helper that maps a bit
// transition onto the {J,K} drive for one cell.
package jk_pkg;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // {J,K} for q -> q_next; never yields the toggle code
   function automatic logic [1:0] excite(input logic q,
                                         input logic q_next);
      return {~q & q_next, q & ~q_next};
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset to 0.
// One of these holds each bit of the counter.
module jk_cell (
   input  logic Clk,
   input  logic Rst_n,
   input  logic J,
   input  logic K,
   output logic Q
);
   import jk_pkg::*;

   logic r_q;

   // JK state update: hold, clear, set or toggle
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_q <= 1'b0;
      end else begin
         unique case ({J, K})
            JK_HOLD:   r_q <= r_q;
            JK_RESET:  r_q <= 1'b0;
            JK_SET:    r_q <= 1'b1;
            JK_TOGGLE: r_q <= ~r_q;
         endcase
      end
   end

   assign Q = r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter stored in a bank of JK cells.
// Define JK_MOD_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module jk_mod_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             Tc,
   output logic             Err,
   output logic [WIDTH-1:0] J_o,
   output logic [WIDTH-1:0] K_o
);
   import jk_pkg::*;

   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("jk_mod_counter: WIDTH out of range 2..16");
   end
   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
      $error("jk_mod_counter: MODULUS out of range 2..2^WIDTH");
   end

   localparam int LP_MOD_I = MODULUS;
   localparam int LP_MAX_I = MODULUS - 1;
   localparam int LP_ONE_I = 1;

   // comparisons use WIDTH+1 bits so MODULUS = 2^WIDTH does not alias
   localparam logic [WIDTH:0]   LP_MOD_X = LP_MOD_I[WIDTH:0];
   localparam logic [WIDTH:0]   LP_MAX_X = LP_MAX_I[WIDTH:0];
   localparam logic [WIDTH:0]   LP_ONE_X = LP_ONE_I[WIDTH:0];
   localparam logic [WIDTH-1:0] LP_MAX_W = LP_MAX_I[WIDTH-1:0];
   localparam logic [WIDTH-1:0] LP_ONE_W = LP_ONE_I[WIDTH-1:0];

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH:0]   w_inc_x;
   logic [WIDTH:0]   w_d_x;
   logic             w_bad;
   logic             w_at_top;
   logic             w_at_zero;
   logic             r_err;

   assign w_inc_x   = {1'b0, w_q} + LP_ONE_X;
   assign w_d_x     = {1'b0, D};
   assign w_at_top  = ({1'b0, w_q} == LP_MAX_X);
   assign w_at_zero = (w_q == '0);

   // next-count selection: load, then count, then hold
   always_comb begin
      w_next = w_q;
      w_bad  = 1'b0;
      if (Load) begin
         if (w_d_x > LP_MAX_X) begin
            w_next = LP_MAX_W;
            w_bad  = 1'b1;
         end else begin
            w_next = D;
         end
      end else if (En && Up) begin
         if (w_inc_x >= LP_MOD_X) begin
`ifdef JK_MOD_COUNTER_SAT_EN
            w_next = w_q;
`else
            w_next = '0;
`endif
         end else begin
            w_next = w_inc_x[WIDTH-1:0];
         end
      end else if (En) begin
         if (w_at_zero) begin
`ifdef JK_MOD_COUNTER_SAT_EN
            w_next = w_q;
`else
            w_next = LP_MAX_W;
`endif
         end else begin
            w_next = w_q - LP_ONE_W;
         end
      end
   end

   // per-bit excitation derived from the current and next count
   always_comb begin
      w_j = '0;
      w_k = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {w_j[i], w_k[i]} = excite(w_q[i], w_next[i]);
      end
   end

   // out-of-range load flag, visible for the cycle after the load
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_bad;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .Clk   (Clk),
         .Rst_n (Rst_n),
         .J     (w_j[g]),
         .K     (w_k[g]),
         .Q     (w_q[g])
      );
   end

   assign Q   = w_q;
   assign J_o = w_j;
   assign K_o = w_k;
   assign Err = r_err;
   assign Tc  = En & ~Load & ((Up & w_at_top) | (~Up & w_at_zero));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (WIDTH=4, MODULUS=10).
// Stimulus pushes per-cycle expectations; a negedge monitor checks them.
module tb_jk_mod_counter;

`ifdef JK_MOD_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       ld = 1'b0;
   logic [3:0] d = 4'd0;
   logic [3:0] q;
   logic       tc;
   logic       err;
   logic [3:0] jo;
   logic [3:0] ko;

   int n_chk  = 0;
   int n_pass = 0;

   // {q, tc, err, j, k}
   logic [13:0] exp_q[$];
   string       nm_q[$];

   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .En    (en),
      .Up    (up),
      .Load  (ld),
      .D     (d),
      .Q     (q),
      .Tc    (tc),
      .Err   (err),
      .J_o   (jo),
      .K_o   (ko)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   // drive one cycle of inputs and record what the DUT must show
   task automatic cyc(input string nm, input logic e, input logic u,
                      input logic l, input logic [3:0] dv,
                      input logic [3:0] eq, input logic etc,
                      input logic eerr, input logic [3:0] ej,
                      input logic [3:0] ek);
      @(posedge clk);
      #1;
      en = e; up = u; ld = l; d = dv;
      exp_q.push_back({eq, etc, eerr, ej, ek});
      nm_q.push_back(nm);
   endtask

   // monitor: outputs are stable mid-cycle
   initial begin
      logic [13:0] e;
      string       n;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            chk({n, ".q"},   {12'd0, q},   {12'd0, e[13:10]});
            chk({n, ".tc"},  {15'd0, tc},  {15'd0, e[9]});
            chk({n, ".err"}, {15'd0, err}, {15'd0, e[8]});
            chk({n, ".j"},   {12'd0, jo},  {12'd0, e[7:4]});
            chk({n, ".k"},   {12'd0, ko},  {12'd0, e[3:0]});
         end
      end
   end

   // independent reference for the random phase
   function automatic logic [4:0] mnext(input logic [3:0] mq,
                                        input logic e, input logic u,
                                        input logic l,
                                        input logic [3:0] dv);
      if (l) return (dv > 4'd9) ? {1'b1, 4'd9} : {1'b0, dv};
      if (e && u) begin
         if (mq == 4'd9) return {1'b0, SAT ? 4'd9 : 4'd0};
         return {1'b0, mq + 4'd1};
      end
      if (e) begin
         if (mq == 4'd0) return {1'b0, SAT ? 4'd0 : 4'd9};
         return {1'b0, mq - 4'd1};
      end
      return {1'b0, mq};
   endfunction

   initial begin
      logic [3:0] nx;
      logic [3:0] mq;
      logic       merr;
      logic [4:0] r;
      logic       e, u, l, mtc;
      logic [3:0] dv;

      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      // inside reset: Q=0, Tc and excitation follow the inputs
      cyc("rst_drive", 1, 0, 0, 4'd0, 4'd0, 1, 0,
          SAT ? 4'b0000 : 4'b1001, 4'b0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      en = 0; up = 0; ld = 0; d = 0;

      for (int i = 0; i < 10; i++) begin
         nx = (i == 9) ? (SAT ? 4'd9 : 4'd0) : 4'(i + 1);
         cyc("up", 1, 1, 0, 4'd0, 4'(i), (i == 9), 0,
             ~4'(i) & nx, 4'(i) & ~nx);
      end
`ifdef JK_MOD_COUNTER_SAT_EN
      repeat (3) cyc("sat_hold", 1, 1, 0, 4'd0, 4'd9, 1, 0,
                     4'b0000, 4'b0000);
      cyc("sat_ld0", 1, 1, 1, 4'd0, 4'd9, 0, 0, 4'b0000, 4'b1001);
`endif
      cyc("down_wrap", 1, 0, 0, 4'd0, 4'd0, 1, 0,
          SAT ? 4'b0000 : 4'b1001, 4'b0000);
      cyc("ld5", 1, 1, 1, 4'd5, SAT ? 4'd0 : 4'd9, 0, 0,
          SAT ? 4'b0101 : 4'b0100, SAT ? 4'b0000 : 4'b1000);
      cyc("ld12", 0, 0, 1, 4'd12, 4'd5, 0, 0, 4'b1000, 4'b0100);
      cyc("ld15", 0, 0, 1, 4'd15, 4'd9, 0, 1, 4'b0000, 4'b0000);
      cyc("hold", 0, 0, 0, 4'd0, 4'd9, 0, 1, 4'b0000, 4'b0000);
      cyc("down9", 1, 0, 0, 4'd0, 4'd9, 0, 0, 4'b0000, 4'b0001);
      cyc("ld0", 0, 0, 1, 4'd0, 4'd8, 0, 0, 4'b0000, 4'b1000);
      cyc("dir0", 1, 1, 0, 4'd0, 4'd0, 0, 0, 4'b0001, 4'b0000);
      cyc("ldwin", 1, 1, 1, 4'd3, 4'd1, 0, 0, 4'b0010, 4'b0000);
      cyc("up3", 1, 1, 0, 4'd0, 4'd3, 0, 0, 4'b0100, 4'b0011);
      cyc("up4", 1, 1, 0, 4'd0, 4'd4, 0, 0, 4'b0001, 4'b0000);
      cyc("up5", 1, 1, 0, 4'd0, 4'd5, 0, 0, 4'b0010, 4'b0001);
      cyc("up6", 1, 1, 0, 4'd0, 4'd6, 0, 0, 4'b0001, 4'b0000);
      cyc("up7", 1, 1, 0, 4'd0, 4'd7, 0, 0, 4'b1000, 4'b0111);

      // asynchronous reset between edges at Q=7
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      en = 0; up = 0; ld = 0; d = 0;
      #1;
      chk("async_rst7.q", {12'd0, q}, 16'd0);
      chk("async_rst7.err", {15'd0, err}, 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // reset while Err is high
      cyc("ld14", 0, 0, 1, 4'd14, 4'd0, 0, 0, 4'b1001, 4'b0000);
      cyc("err_hi", 0, 0, 0, 4'd0, 4'd9, 0, 1, 4'b0000, 4'b0000);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      en = 0; up = 0; ld = 0; d = 0;
      #1;
      chk("async_rst_err.q", {12'd0, q}, 16'd0);
      chk("async_rst_err.err", {15'd0, err}, 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // random phase against the reference model
      mq = 4'd0;
      merr = 1'b0;
      for (int i = 0; i < 300; i++) begin
         e  = 1'($urandom_range(0, 3) != 0);
         u  = 1'($urandom_range(0, 1));
         l  = 1'($urandom_range(0, 7) == 0);
         dv = 4'($urandom_range(0, 15));
         r  = mnext(mq, e, u, l, dv);
         mtc = e & ~l & ((u & (mq == 4'd9)) | (~u & (mq == 4'd0)));
         cyc("rand", e, u, l, dv, mq, mtc, merr,
             ~mq & r[3:0], mq & ~r[3:0]);
         mq = r[3:0];
         merr = r[4];
      end

      repeat (3) @(posedge clk);
      chk("drain", 16'(exp_q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
